mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-access stage directly downstream of the execute unit. Consumes its WB fields (regcData/regcAddr/regcWr) and memory request (memAddr/memData/readWr/writeWr/rmask/wmask).
- Runs a req/ack handshake to the data-memory bus, then extracts and extends load data.
- Presents a registered one-cycle write-back pulse to the register-file stage.
- Stalls upstream while a bus access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in BUS without bus_ack before abort; must be ≥2.
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  stage can accept; high only in IDLE.
- regcData_i  in  32  ALU result.
- regcAddr_i  in  5  WB register address.
- regcWr_i  in  1  WB enable.
- memAddr_i  in  32  byte address.
- memData_i  in  32  store data, LSB-justified.
- readWr_i  in  1  load request.
- writeWr_i  in  1  store request.
- rmask_i  in  4  load byte-lane mask.
- wmask_i  in  4  store byte-lane mask.
- load_signed_i  in  1  1 = sign-extend sub-word load.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address.
- bus_wdata  out  32  lane-replicated write data.
- bus_wstrb  out  4  write strobes.
- bus_ack  in  1  bus completion, one cycle.
- bus_rdata  in  32  read data, valid with bus_ack.
- valid_o  out  1  WB pulse.
- regcData_o  out  32  WB data.
- regcAddr_o  out  5  WB address.
- regcWr_o  out  1  WB enable, qualified by valid_o.
- err_o  out  1  one-cycle pulse: misaligned mask, read+write conflict, or timeout.

Behaviour:
- Reset (async, rst_n low): state=IDLE; counter=0; all outputs 0 except ready_o=1. bus_req falls immediately, even mid-transaction.
- FSM states: IDLE, BUS.
- IDLE:
  - ready_o=1. Accept on valid_i&&ready_o.
  - Non-memory op (readWr_i=writeWr_i=0): next cycle valid_o=1 with regc fields copied. Latency 1.
  - Legal memory op: latch request, go BUS; bus_req=1 from next cycle.
  - Illegal op (readWr_i&&writeWr_i, or mask not in legal set): no bus access; next cycle valid_o=1, regcWr_o=0, err_o=1.
- Legal masks, same set for rmask (loads) and wmask (stores): 1111; 0001/0010/0100/1000 (byte); 0011/1100 (half).
- BUS:
  - ready_o=0.
  - bus_req=1, bus_we=writeWr; bus_addr={addr[31:2],2'b00}; bus_wstrb=wmask (0 for loads). All held stable until ack.
  - bus_wdata: byte → {4{d[7:0]}}; half → {2{d[15:0]}}; word → d.
  - Counter increments each BUS cycle.
  - On bus_ack: bus_req drops the same edge; next cycle valid_o=1, state IDLE.
    - Load: regcData_o = selected lane of bus_rdata, zero- or sign-extended per load_signed_i; word passes through; regcWr_o = latched regcWr.
    - Store: regcData_o = latched ALU result; regcWr_o = latched regcWr.
  - Timeout: counter==TIMEOUT_CYCLES-1 with no ack → drop bus_req, valid_o=1, regcWr_o=0, err_o=1, return IDLE.
- Outputs:
  - valid_o and err_o are single-cycle pulses; WB has no backpressure.
  - regc*_o hold their last value when valid_o=0.
- Boundaries:
  - bus_ack while IDLE is ignored.
  - bus_ack on the timeout cycle counts as ack; no error.
  - valid_i low → no action.
  - Upstream must hold inputs while ready_o=0.
  - Back-to-back non-memory ops sustain 1 per cycle.
  - Min memory-op occupancy: accept cycle + 1 BUS cycle.

Test Plan:
- Reset mid-BUS: rst_n low while bus_req=1 → bus_req=0 asynchronously; after release ready_o=1, valid_o=0.
- Non-memory: regcData_i=0x12345678, addr=5, wr=1 → next cycle valid_o=1, regcData_o=0x12345678, regcAddr_o=5, ready_o stays 1.
- Signed byte load: memAddr=0x1002, rmask=0100, signed=1, ack after 3 cycles with rdata=0x00800000.
  - bus_addr=0x1000, bus_we=0.
  - regcData_o=0xFFFFFF80, one valid_o pulse.
  - ready_o low throughout BUS.
- Half store: memAddr=0x2002, wmask=1100, memData=0xABCD → bus_wdata=0xABCDABCD, bus_wstrb=1100, bus_we=1 until ack.
- Timeout: TIMEOUT_CYCLES=4, no ack → bus_req high exactly 4 cycles; then valid_o=1, regcWr_o=0, err_o=1.
- Illegal: rmask=0110, readWr=1 → no bus_req; next cycle err_o=1, regcWr_o=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access stage: turns execute-stage load/store requests into req/ack bus
// transactions and produces a registered one-cycle write-back pulse.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] regcData_i,
  input  logic [4:0]  regcAddr_i,
  input  logic        regcWr_i,
  input  logic [31:0] memAddr_i,
  input  logic [31:0] memData_i,
  input  logic        readWr_i,
  input  logic        writeWr_i,
  input  logic [3:0]  rmask_i,
  input  logic [3:0]  wmask_i,
  input  logic        load_signed_i,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        valid_o,
  output logic [31:0] regcData_o,
  output logic [4:0]  regcAddr_o,
  output logic        regcWr_o,
  output logic        err_o
);

  // Upstream handshake: a request transfers on a rising edge where valid_i && ready_o;
  // ready_o is high only in IDLE, and upstream holds its inputs while ready_o is low.
  typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [29:0]      addr_q;
  logic [31:0]      wdata_q, alu_q;
  logic [3:0]       wstrb_q, rmask_q;
  logic [4:0]       waddr_q;
  logic             we_q, sign_q, wr_q;
  logic             accept, is_mem, illegal, timeout;

  function automatic logic mask_ok(input logic [3:0] m);
    case (m)
      4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [3:0] m, input logic [31:0] d);
    case (m)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return {4{d[7:0]}};
      4'b0011, 4'b1100:                   return {2{d[15:0]}};
      default:                            return d;
    endcase
  endfunction

  // Pick the lane named by the load mask and extend it to 32 bits.
  function automatic logic [31:0] extract(input logic [3:0] m, input logic [31:0] r,
                                          input logic s);
    logic [7:0]  b;
    logic [15:0] h;
    b = r[7:0];
    h = r[15:0];
    case (m)
      4'b0010: b = r[15:8];
      4'b0100: b = r[23:16];
      4'b1000: b = r[31:24];
      4'b1100: h = r[31:16];
      default: ;
    endcase
    case (m)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return {{24{s & b[7]}}, b};
      4'b0011, 4'b1100:                   return {{16{s & h[15]}}, h};
      default:                            return r;
    endcase
  endfunction

  assign accept  = valid_i && (state_q == IDLE);
  assign is_mem  = readWr_i || writeWr_i;
  assign illegal = (readWr_i && writeWr_i) || (readWr_i && !mask_ok(rmask_i)) ||
                   (writeWr_i && !mask_ok(wmask_i));
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    ready_o   = (state_q == IDLE);
    bus_req   = (state_q == BUS);
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wstrb = '0;
    case (state_q)
      IDLE: if (accept && is_mem && !illegal) state_d = BUS;
      BUS: begin
        bus_we    = we_q;
        bus_addr  = {addr_q, 2'b00};
        bus_wdata = wdata_q;
        bus_wstrb = wstrb_q;
        if (bus_ack || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      alu_q      <= '0;
      wstrb_q    <= '0;
      rmask_q    <= '0;
      waddr_q    <= '0;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      wr_q       <= 1'b0;
      valid_o    <= 1'b0;
      err_o      <= 1'b0;
      regcData_o <= '0;
      regcAddr_o <= '0;
      regcWr_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (accept) begin
            if (illegal || !is_mem) begin
              valid_o    <= 1'b1;
              err_o      <= illegal;
              regcData_o <= regcData_i;
              regcAddr_o <= regcAddr_i;
              regcWr_o   <= regcWr_i && !illegal;
            end else begin
              addr_q  <= memAddr_i[31:2];
              we_q    <= writeWr_i;
              wstrb_q <= writeWr_i ? wmask_i : 4'b0000;
              wdata_q <= writeWr_i ? replicate(wmask_i, memData_i) : 32'h0;
              rmask_q <= rmask_i;
              sign_q  <= load_signed_i;
              alu_q   <= regcData_i;
              waddr_q <= regcAddr_i;
              wr_q    <= regcWr_i;
            end
          end
        end
        BUS: begin
          cnt_q <= cnt_q + 1'b1;
          // An ack on the final allowed cycle wins over the timeout.
          if (bus_ack) begin
            valid_o    <= 1'b1;
            regcAddr_o <= waddr_q;
            regcWr_o   <= wr_q;
            regcData_o <= we_q ? alu_q : extract(rmask_q, bus_rdata, sign_q);
          end else if (timeout) begin
            valid_o    <= 1'b1;
            err_o      <= 1'b1;
            regcAddr_o <= waddr_q;
            regcData_o <= alu_q;
            regcWr_o   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized ops scored
// against a lane/size-arithmetic model of loads, stores and error cases.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_o;
  logic [31:0] regcData_i, memAddr_i, memData_i;
  logic [4:0]  regcAddr_i;
  logic        regcWr_i, readWr_i, writeWr_i, load_signed_i;
  logic [3:0]  rmask_i, wmask_i;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        valid_o, regcWr_o, err_o;
  logic [31:0] regcData_o;
  logic [4:0]  regcAddr_o;

  mem_access_unit #(.TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .regcData_i(regcData_i), .regcAddr_i(regcAddr_i), .regcWr_i(regcWr_i),
    .memAddr_i(memAddr_i), .memData_i(memData_i), .readWr_i(readWr_i),
    .writeWr_i(writeWr_i), .rmask_i(rmask_i), .wmask_i(wmask_i),
    .load_signed_i(load_signed_i), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .valid_o(valid_o),
    .regcData_o(regcData_o), .regcAddr_o(regcAddr_o), .regcWr_o(regcWr_o),
    .err_o(err_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- types / scoreboard ----------------
  typedef struct {
    logic [31:0] alu, maddr, mdata, rdata;
    logic [4:0]  waddr;
    logic        wr, rd, st, sgn;
    logic [3:0]  rmask, wmask;
    int          delay;
  } op_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
    logic [4:0]  addr;
    logic        wr;
    logic        err;
    logic        chk;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic        exp_bus_active = 1'b0;
  logic [31:0] exp_addr, exp_wdata;
  logic        exp_we;
  logic [3:0]  exp_wstrb;

  logic [31:0] last_addr, last_wdata;
  logic        last_we;
  logic [3:0]  last_wstrb;
  int          req_cycles = 0;
  int          vcount = 0;
  int          ecount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int lane_lo(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int lane_n(input logic [3:0] m);
    int n = 0;
    for (int i = 0; i < 4; i++) if (m[i]) n++;
    return n;
  endfunction

  // Legal: a naturally aligned contiguous run of 1, 2 or 4 bytes.
  function automatic bit legal(input logic [3:0] m);
    int n, lo;
    n  = lane_n(m);
    lo = lane_lo(m);
    if (!(n == 1 || n == 2 || n == 4)) return 0;
    if (lo % n != 0) return 0;
    return m == 4'(((1 << n) - 1) << lo);
  endfunction

  function automatic logic [31:0] load_model(input logic [3:0] m, input logic [31:0] r,
                                             input logic s);
    int n, lo;
    logic [63:0] v, lm;
    n  = lane_n(m);
    lo = lane_lo(m);
    lm = (64'd1 << (8 * n)) - 64'd1;
    v  = ({32'h0, r} >> (8 * lo)) & lm;
    if (s && n < 4 && v[8*n-1]) v = v | ~lm;
    return v[31:0];
  endfunction

  function automatic logic [31:0] wdata_model(input logic [3:0] m, input logic [31:0] d);
    logic [31:0] o;
    int n;
    n = lane_n(m);
    for (int i = 0; i < 4; i++) o[8*i +: 8] = d[8*(i % n) +: 8];
    return o;
  endfunction

  function automatic bit is_bad(input op_t op);
    return (op.rd && op.st) || (op.rd && !legal(op.rmask)) || (op.st && !legal(op.wmask));
  endfunction

  function automatic exp_t model(input op_t op);
    exp_t e;
    e = '0;
    if (is_bad(op)) begin
      e.err = 1'b1;
    end else if (!op.rd && !op.st) begin
      e.data = op.alu; e.addr = op.waddr; e.wr = op.wr; e.chk = 1'b1;
    end else if (op.delay >= T) begin
      e.err = 1'b1;
    end else begin
      e.chk  = 1'b1;
      e.addr = op.waddr;
      e.wr   = op.wr;
      e.data = op.rd ? load_model(op.rmask, op.rdata, op.sgn) : op.alu;
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  function automatic op_t blank();
    op_t op;
    op.alu = 0; op.maddr = 0; op.mdata = 0; op.rdata = 0; op.waddr = 0;
    op.wr = 0; op.rd = 0; op.st = 0; op.sgn = 0; op.rmask = 4'hF; op.wmask = 4'hF;
    op.delay = 0;
    return op;
  endfunction

  function automatic logic [3:0] pick_mask();
    if ($urandom_range(0, 3) == 0) return 4'($urandom);
    case ($urandom_range(0, 6))
      0: return 4'b1111;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0100;
      4: return 4'b1000;
      5: return 4'b0011;
      default: return 4'b1100;
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t op;
    int kind;
    op.alu = $urandom; op.maddr = $urandom; op.mdata = $urandom; op.rdata = $urandom;
    op.waddr = 5'($urandom); op.wr = 1'($urandom); op.sgn = 1'($urandom);
    op.rmask = pick_mask(); op.wmask = pick_mask();
    kind  = $urandom_range(0, 9);
    op.rd = (kind >= 3 && kind <= 5) || kind == 9;
    op.st = kind >= 6;
    op.delay = ($urandom_range(0, 5) == 0) ? T : $urandom_range(0, T - 1);
    return op;
  endfunction

  task automatic drive_fields(input op_t op);
    regcData_i = op.alu; regcAddr_i = op.waddr; regcWr_i = op.wr;
    memAddr_i = op.maddr; memData_i = op.mdata; readWr_i = op.rd; writeWr_i = op.st;
    rmask_i = op.rmask; wmask_i = op.wmask; load_signed_i = op.sgn;
  endtask

  task automatic set_bus_exp(input op_t op);
    exp_addr  = op.maddr & 32'hFFFF_FFFC;
    exp_we    = op.st;
    exp_wstrb = op.st ? op.wmask : 4'b0000;
    exp_wdata = wdata_model(op.wmask, op.mdata);
    exp_bus_active = 1'b1;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the WB cycle.
  task automatic run_op(input op_t op);
    exp_t e;
    int   k;
    bit   done;
    e = model(op);
    drive_fields(op);
    valid_i   = 1'b1;
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    @(posedge clk); #1;
    valid_i = 1'b0;
    bus_ack = 1'b0;
    if (!is_bad(op) && (op.rd || op.st)) begin
      set_bus_exp(op);
      k = 0;
      done = 0;
      while (!done) begin
        bus_ack   = (k == op.delay);
        bus_rdata = bus_ack ? op.rdata : $urandom;
        @(posedge clk); #1;
        if (k == op.delay || k == T - 1) done = 1;
        k++;
      end
      bus_ack = 1'b0;
      exp_bus_active = 1'b0;
    end
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid_i    = 1'b0;
      regcData_i = $urandom;
      readWr_i   = 1'($urandom);
      bus_ack    = 1'($urandom);
      bus_rdata  = $urandom;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // ---------------- compare process ----------------
  task automatic monitor();
    exp_t e;
    bit   ev;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("ready_o", ready_o, !exp_bus_active);
        check("bus_req", bus_req, exp_bus_active);
        if (bus_req) begin
          req_cycles++;
          last_addr = bus_addr; last_we = bus_we;
          last_wstrb = bus_wstrb; last_wdata = bus_wdata;
        end
        if (exp_bus_active) begin
          check("bus_addr", bus_addr, exp_addr);
          check("bus_we", bus_we, exp_we);
          check("bus_wstrb", bus_wstrb, exp_wstrb);
          if (exp_we) check("bus_wdata", bus_wdata, exp_wdata);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
        ev = exp_q.size() > 0 && exp_q[0].cyc == cyc;
        e  = ev ? exp_q[0] : '0;
        check("valid_o", valid_o, ev);
        check("err_o", err_o, e.err);
        if (valid_o) vcount++;
        if (err_o) ecount++;
        if (ev && valid_o) begin
          check("regcWr_o", regcWr_o, e.wr);
          if (e.chk) begin
            check("regcData_o", regcData_o, e.data);
            check("regcAddr_o", regcAddr_o, e.addr);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    op_t op;
    int  v0, e0, r0;
    rst_n = 1'b0; valid_i = 0; bus_ack = 0; bus_rdata = 0;
    drive_fields(blank());
    fork
      monitor();
    join_none

    #3;
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_err", err_o, 0);
    check("rst_data", regcData_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Non-memory op, latency 1
    op = blank(); op.alu = 32'h1234_5678; op.waddr = 5; op.wr = 1;
    run_op(op);
    check("nm_valid", valid_o, 1);
    check("nm_data", regcData_o, 32'h1234_5678);
    check("nm_addr", regcAddr_o, 5);
    check("nm_ready", ready_o, 1);

    // Back-to-back non-memory ops
    settle();
    v0 = vcount;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      op = blank(); op.alu = 32'hA0 + i; op.waddr = 5'(i + 1); op.wr = 1;
      run_op(op);
    end
    idle(1);
    check("b2b_count", vcount - v0, 3);

    // Signed byte load
    v0 = vcount;
    op = blank(); op.maddr = 32'h1002; op.rd = 1; op.rmask = 4'b0100; op.sgn = 1;
    op.rdata = 32'h0080_0000; op.delay = 2; op.waddr = 7; op.wr = 1;
    run_op(op);
    check("ldb_data", regcData_o, 32'hFFFF_FF80);
    settle();
    check("ldb_addr", last_addr, 32'h1000);
    check("ldb_we", last_we, 0);
    check("ldb_pulses", vcount - v0, 1);
    @(posedge clk); #1;

    // Half store
    op = blank(); op.maddr = 32'h2002; op.st = 1; op.wmask = 4'b1100;
    op.mdata = 32'h0000_ABCD; op.alu = 32'h55; op.delay = 1; op.wr = 1;
    run_op(op);
    settle();
    check("sth_wdata", last_wdata, 32'hABCD_ABCD);
    check("sth_wstrb", last_wstrb, 4'b1100);
    check("sth_we", last_we, 1);
    @(posedge clk); #1;

    // Timeout: no ack at all
    r0 = req_cycles; e0 = ecount;
    op = blank(); op.maddr = 32'h3000; op.rd = 1; op.delay = T; op.wr = 1;
    run_op(op);
    check("to_wr", regcWr_o, 0);
    check("to_err", err_o, 1);
    settle();
    check("to_req_cycles", req_cycles - r0, T);
    check("to_err_count", ecount - e0, 1);
    @(posedge clk); #1;

    // Ack on the timeout cycle counts as success
    e0 = ecount;
    op = blank(); op.maddr = 32'h3004; op.rd = 1; op.rdata = 32'hCAFE_F00D;
    op.delay = T - 1; op.wr = 1;
    run_op(op);
    check("ackto_data", regcData_o, 32'hCAFE_F00D);
    check("ackto_wr", regcWr_o, 1);
    settle();
    check("ackto_err_count", ecount - e0, 0);
    @(posedge clk); #1;

    // Illegal read mask
    r0 = req_cycles; e0 = ecount;
    op = blank(); op.rd = 1; op.rmask = 4'b0110; op.wr = 1;
    run_op(op);
    check("ill_wr", regcWr_o, 0);
    settle();
    check("ill_req_cycles", req_cycles - r0, 0);
    check("ill_err_count", ecount - e0, 1);
    @(posedge clk); #1;

    // Reset while a bus access is outstanding
    op = blank(); op.maddr = 32'h4000; op.rd = 1;
    drive_fields(op);
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    set_bus_exp(op);
    @(posedge clk); #2;
    check("mid_req_before", bus_req, 1);
    rst_n = 1'b0;
    #1;
    check("mid_req_async", bus_req, 0);
    exp_bus_active = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_ready", ready_o, 1);
    check("mid_valid", valid_o, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      run_op(rand_op());
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(3);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
